video_proc_ctrl: RTL
====================

# video_proc_ctrl

Frame-synchronous controller for the grey-scale video processing chain (RAW-to-grey, median, Sobel, erosion, dilation). Accepts stage-enable and Sobel-threshold updates from a register/host interface at any time. It applies them only at a frame start, so no frame is ever processed with mixed settings. It also counts frames and checks incoming frame geometry against the configured resolution. Sits beside the processing chain on the pixel clock and drives its stage bypass selects and threshold input.

## Interface
- IMG_HDISP, 11'd640, expected active pixels per line
- IMG_VDISP, 11'd480, expected active lines per frame
- DEF_THRESHOLD, 8'd64, Sobel threshold after reset
- clk  in  1  CMOS video pixel clock; the block's only clock
- rst_n  in  1  reset, asynchronous assert, active-low
- per_frame_vsync  in  1  frame valid, high during a frame
- per_frame_href  in  1  line valid, high during active pixels
- cfg_valid  in  1  host offers a new configuration
- cfg_ready  out  1  block can accept a configuration
- cfg_stage_en  in  4  requested enables: [0] median, [1] Sobel, [2] erosion, [3] dilation
- cfg_threshold  in  8  requested Sobel threshold
- act_stage_en  out  4  active enables to the chain; reset 4'b0000 (full bypass)
- act_threshold  out  8  active Sobel threshold; reset DEF_THRESHOLD
- cfg_applied  out  1  one-cycle pulse when pending configuration becomes active; reset 0
- in_frame  out  1  high in FRAME state; reset 0
- frame_cnt  out  16  completed frames, wraps 16'hFFFF→0; reset 0
- geom_err  out  2  [0] line-length error, [1] line-count error of last completed frame; reset 0

## Operation
- vsync and href are registered once (vs_d, hs_d). Edges are detected against the live inputs: rise = vsync & ~vs_d, fall = ~vsync & vs_d.
- State machine, encoding in the package:
  - WAIT_SYNC (reset state): discards any partial frame. Goes to BLANK when vsync is sampled 0.
  - BLANK: goes to FRAME on vsync rise. If a pending configuration exists, it is loaded into act_* and pending is cleared.
  - FRAME: goes to BLANK on vsync fall. frame_cnt increments and geom_err updates.
- Configuration handshake, one-entry pending buffer:
  - cfg_ready = ~pending.
  - Transfer occurs when cfg_valid & cfg_ready. Inputs are captured and pending is set.
  - A transfer in the same cycle as a BLANK→FRAME rise is not applied to that frame; it waits for the next frame start.
  - Pending full at frame start: applied, and cfg_ready returns high the following cycle.
- Geometry check (see Configuration):
  - hcnt counts href-high cycles and saturates at 2047.
  - A line ends on href fall, or on vsync fall while href is high. At line end, hcnt≠IMG_HDISP sets the frame's line-length flag, vcnt increments, and hcnt clears.
  - At frame end, vcnt≠IMG_VDISP sets the line-count flag. Both flags are copied to geom_err and held until the next frame end. Frame-local flags and counters then clear.
  - Counting only occurs in FRAME state.
- Reset asserted mid-frame: all outputs return to reset values immediately and pending is dropped. After release the block sits in WAIT_SYNC until vsync is low.

## Timing
- Let T be the first cycle vsync is sampled 1 in BLANK. act_* changes at the clock edge ending T, so it is visible from T+1. cfg_applied is high during T+1 only.
- Upstream contract: href stays low in cycle T. The chain's first pixel therefore always sees the new settings.
- in_frame rises at T+1. It falls in the cycle after vsync is first sampled 0.
- frame_cnt and geom_err update one cycle after the vsync fall is detected.
- cfg_ready deasserts the cycle after a transfer.

## Configuration
- GEOM_CHECK_EN defined: hcnt/vcnt counters and geom_err logic are compiled in.
- GEOM_CHECK_EN undefined: the counters are removed and geom_err is tied 2'b00. frame_cnt, the state machine and the handshake are unchanged.

## Structure
- Shared package video_proc_pkg contains:
  - stage-index constants STG_MEDIAN=0, STG_SOBEL=1, STG_EROSION=2, STG_DILATION=3
  - state encoding (WAIT_SYNC, BLANK, FRAME)
  - default threshold constant
- One sub-module: video_geom_checker (hcnt/vcnt, line/frame-end compare, flags). It is instantiated under GEOM_CHECK_EN.

## Test plan
All scenarios use IMG_HDISP=8, IMG_VDISP=4, frames of 4 lines × 8 pixels.
- Reset release with vsync high mid-frame → no cfg_applied, frame_cnt stays 0 until the first full frame completes, then frame_cnt=1.
- Offer cfg_stage_en=4'b0010, cfg_threshold=8'd100 during BLANK → cfg_ready low next cycle; act_stage_en=4'b0010, act_threshold=100 from T+1; cfg_applied pulses once; cfg_ready high at T+2.
- Offer config during FRAME → act_* unchanged until the next vsync rise; a second offer is stalled (cfg_ready=0) until that frame start.
- Transfer in exactly cycle T → not applied this frame; applied at the following frame start.
- One line with 7 pixels → geom_err=2'b01 after that frame. A frame with 3 lines → 2'b10. The next clean frame → 2'b00.
- Preload frame_cnt to 16'hFFFF (force) and complete one frame → frame_cnt=0. Assert rst_n mid-frame → act_stage_en=0, act_threshold=DEF_THRESHOLD immediately.

Source files
------------

// File: rtl/video_proc_pkg.sv
// Shared constants and state encoding for the video processing controller.
package video_proc_pkg;

  // Bit positions inside the stage-enable vector
  localparam int unsigned STG_MEDIAN   = 0;
  localparam int unsigned STG_SOBEL    = 1;
  localparam int unsigned STG_EROSION  = 2;
  localparam int unsigned STG_DILATION = 3;

  localparam logic [7:0] VP_DEF_THRESHOLD = 8'd64;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    BLANK     = 2'd1,
    FRAME     = 2'd2
  } state_e;

endpackage

// File: rtl/video_geom_checker.sv
// Frame geometry checker: counts pixels per line and lines per frame while
// the controller is in FRAME, and latches error flags at each frame end.
module video_geom_checker #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_en_i,
  input  logic       href_i,
  input  logic       href_d_i,
  input  logic       frame_end_i,
  output logic [1:0] geom_err_o
);

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        len_err_q, len_err_d;
  logic [1:0]  geom_err_q, geom_err_d;

  logic        line_end;
  logic [10:0] hcnt_now;
  logic [10:0] vcnt_now;
  logic        len_err_now;

  // Next-state for counters and flags; a line still open at vsync fall is closed with it
  always_comb begin
    hcnt_now    = (href_i && (hcnt_q != '1)) ? hcnt_q + 11'd1 : hcnt_q;
    line_end    = (~href_i & href_d_i) | (frame_end_i & href_i);
    vcnt_now    = (line_end && (vcnt_q != '1)) ? vcnt_q + 11'd1 : vcnt_q;
    len_err_now = len_err_q | (line_end & (hcnt_now != IMG_HDISP));

    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    len_err_d  = len_err_q;
    geom_err_d = geom_err_q;

    if (count_en_i) begin
      if (frame_end_i) begin
        geom_err_d = {(vcnt_now != IMG_VDISP), len_err_now};
        hcnt_d     = '0;
        vcnt_d     = '0;
        len_err_d  = 1'b0;
      end else begin
        hcnt_d    = line_end ? '0 : hcnt_now;
        vcnt_d    = vcnt_now;
        len_err_d = len_err_now;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      len_err_q  <= 1'b0;
      geom_err_q <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      len_err_q  <= len_err_d;
      geom_err_q <= geom_err_d;
    end
  end

  assign geom_err_o = geom_err_q;

endmodule

// File: rtl/video_proc_ctrl.sv
// Frame-synchronous configuration controller for the grey-scale video chain.
// Host configuration is buffered in a one-entry pending slot and applied only
// at a frame start. Optional geometry checking is compiled in with the macro
// GEOM_CHECK_EN; without it geom_err is tied to 2'b00.
module video_proc_ctrl
  import video_proc_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP     = 11'd640,
  parameter logic [10:0] IMG_VDISP     = 11'd480,
  parameter logic [7:0]  DEF_THRESHOLD = VP_DEF_THRESHOLD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_stage_en,
  input  logic [7:0]  cfg_threshold,
  output logic [3:0]  act_stage_en,
  output logic [7:0]  act_threshold,
  output logic        cfg_applied,
  output logic        in_frame,
  output logic [15:0] frame_cnt,
  output logic [1:0]  geom_err
);

  state_e      state_q;
  logic        vs_d_q;
  logic        pending_q;
  logic [3:0]  pend_stage_q;
  logic [7:0]  pend_thr_q;
  logic [3:0]  act_stage_q;
  logic [7:0]  act_thr_q;
  logic        cfg_applied_q;
  logic        in_frame_q;
  logic [15:0] frame_cnt_q;

  logic vs_rise;
  logic vs_fall;
  logic cfg_xfer;

  assign vs_rise   = per_frame_vsync & ~vs_d_q;
  assign vs_fall   = ~per_frame_vsync & vs_d_q;
  assign cfg_ready = ~pending_q;
  assign cfg_xfer  = cfg_valid & ~pending_q;

  // Delayed vsync for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q <= 1'b0;
    end else begin
      vs_d_q <= per_frame_vsync;
    end
  end

  // Frame FSM, pending buffer and registered outputs; a transfer and an apply
  // never coincide because a transfer needs the pending slot empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_SYNC;
      pending_q     <= 1'b0;
      pend_stage_q  <= '0;
      pend_thr_q    <= '0;
      act_stage_q   <= '0;
      act_thr_q     <= DEF_THRESHOLD;
      cfg_applied_q <= 1'b0;
      in_frame_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      cfg_applied_q <= 1'b0;
      if (cfg_xfer) begin
        pending_q    <= 1'b1;
        pend_stage_q <= cfg_stage_en;
        pend_thr_q   <= cfg_threshold;
      end
      case (state_q)
        WAIT_SYNC: begin
          if (!per_frame_vsync) state_q <= BLANK;
        end
        BLANK: begin
          if (vs_rise) begin
            state_q    <= FRAME;
            in_frame_q <= 1'b1;
            if (pending_q) begin
              act_stage_q   <= pend_stage_q;
              act_thr_q     <= pend_thr_q;
              pending_q     <= 1'b0;
              cfg_applied_q <= 1'b1;
            end
          end
        end
        FRAME: begin
          if (vs_fall) begin
            state_q     <= BLANK;
            in_frame_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign act_stage_en  = act_stage_q;
  assign act_threshold = act_thr_q;
  assign cfg_applied   = cfg_applied_q;
  assign in_frame      = in_frame_q;
  assign frame_cnt     = frame_cnt_q;

`ifdef GEOM_CHECK_EN
  logic hs_d_q;

  // Delayed href for line-end detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d_q <= 1'b0;
    end else begin
      hs_d_q <= per_frame_href;
    end
  end

  video_geom_checker #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_geom (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_en_i  (state_q == FRAME),
    .href_i      (per_frame_href),
    .href_d_i    (hs_d_q),
    .frame_end_i ((state_q == FRAME) && vs_fall),
    .geom_err_o  (geom_err)
  );
`else
  assign geom_err = 2'b00;
`endif

endmodule
